// File: rtl/throw_ctrl_if.sv
// rtl/throw_ctrl_if.sv - mouse, speed and physics signal bundle for throw_ctrl
interface throw_ctrl_if;
    logic               i_mouse_left;
    logic signed [15:0] i_x_vel;
    logic signed [15:0] i_y_vel;
    logic signed [15:0] i_z_vel;
    logic               i_collision_done;
    logic               o_launch;
    logic signed [15:0] o_x_vel;
    logic signed [15:0] o_y_vel;
    logic signed [15:0] o_z_vel;
    logic               o_speed_clr;
    logic               o_abort;
    logic               o_timeout;
    logic               o_busy;
    logic [2:0]         o_state;
    logic [7:0]         o_throw_cnt;

    modport master (
        output i_mouse_left, i_x_vel, i_y_vel, i_z_vel, i_collision_done,
        input  o_launch, o_x_vel, o_y_vel, o_z_vel, o_speed_clr,
        input  o_abort, o_timeout, o_busy, o_state, o_throw_cnt
    );

    modport slave (
        input  i_mouse_left, i_x_vel, i_y_vel, i_z_vel, i_collision_done,
        output o_launch, o_x_vel, o_y_vel, o_z_vel, o_speed_clr,
        output o_abort, o_timeout, o_busy, o_state, o_throw_cnt
    );
endinterface

// File: rtl/throw_ctrl.sv
// rtl/throw_ctrl.sv - one-throw sequencer: debounce, drag timing, launch, flight, speed clear
// Optional THROW_CLAMP_EN saturates captured velocities to +/-MAX_VEL.
module throw_ctrl #(
    parameter int DEBOUNCE = 4,
    parameter int MIN_HOLD = 8,
    parameter int TIMEOUT  = 1000000,
    parameter int MAX_VEL  = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    throw_ctrl_if.slave bus
);
    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam int HW  = $clog2(MIN_HOLD + 1);

    localparam logic [DBW-1:0]     DB_LAST   = DBW'(DEBOUNCE - 1);
    localparam logic [HW-1:0]      HOLD_MAX  = HW'(MIN_HOLD);
    localparam logic [23:0]        FLT_LAST  = 24'(TIMEOUT - 1);
    localparam logic signed [15:0] VMAX      = 16'(MAX_VEL);
    localparam logic signed [15:0] VMIN      = 16'(-MAX_VEL);

`ifdef THROW_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAG   = 3'd1,
        LAUNCH = 3'd2,
        FLIGHT = 3'd3,
        CLEAR  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DBW-1:0]     db_q, db_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [23:0]        flt_q, flt_d;
    logic               abort_q, abort_d;
    logic               timeout_q, timeout_d;
    logic               capture;
    logic [7:0]         cnt_q;
    logic signed [15:0] x_q, y_q, z_q;

    function automatic logic signed [15:0] shape(input logic signed [15:0] v);
        if (CLAMP_EN && (v > VMAX)) return VMAX;
        if (CLAMP_EN && (v < VMIN)) return VMIN;
        return v;
    endfunction

    always_comb begin
        state_d   = state_q;
        db_d      = '0;
        hold_d    = hold_q;
        flt_d     = flt_q;
        abort_d   = 1'b0;
        timeout_d = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_mouse_left) begin
                    if (db_q == DB_LAST) begin
                        state_d = DRAG;
                        hold_d  = '0;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end
            end
            DRAG: begin
                if (!bus.i_mouse_left) begin
                    if (hold_q >= HOLD_MAX) begin
                        capture = 1'b1;
                        state_d = LAUNCH;
                    end else begin
                        abort_d = 1'b1;
                        state_d = CLEAR;
                    end
                end else if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            LAUNCH: begin
                state_d = FLIGHT;
                flt_d   = '0;
            end
            FLIGHT: begin
                flt_d = flt_q + 1'b1;
                // Collision wins a tie with the timeout
                if (bus.i_collision_done) begin
                    state_d = CLEAR;
                end else if (flt_q == FLT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                if (!bus.i_mouse_left) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            db_q      <= '0;
            hold_q    <= '0;
            flt_q     <= '0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
        end else begin
            state_q   <= state_d;
            db_q      <= db_d;
            hold_q    <= hold_d;
            flt_q     <= flt_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
            if (capture) begin
                x_q <= shape(bus.i_x_vel);
                y_q <= shape(bus.i_y_vel);
                z_q <= shape(bus.i_z_vel);
            end
            if (state_q == LAUNCH) cnt_q <= cnt_q + 8'd1;
        end
    end

    assign bus.o_launch    = (state_q == LAUNCH);
    assign bus.o_speed_clr = (state_q == CLEAR);
    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_state     = state_q;
    assign bus.o_abort     = abort_q;
    assign bus.o_timeout   = timeout_q;
    assign bus.o_throw_cnt = cnt_q;
    assign bus.o_x_vel     = x_q;
    assign bus.o_y_vel     = y_q;
    assign bus.o_z_vel     = z_q;
endmodule

// File: tb/tb_throw_ctrl.sv
// tb/tb_throw_ctrl.sv - directed bench for throw_ctrl with a velocity scoreboard
module tb_throw_ctrl;
    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    throw_ctrl_if bus();

    throw_ctrl #(
        .DEBOUNCE(4),
        .MIN_HOLD(8),
        .TIMEOUT(100),
        .MAX_VEL(255)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } vel_t;

    vel_t               sb[$];
    int                 errors = 0;
    int                 checks = 0;
    logic [7:0]         exp_cnt = 8'd0;
    logic signed [15:0] last_x = 16'sd0;
    logic signed [15:0] last_y = 16'sd0;
    logic signed [15:0] last_z = 16'sd0;

    function automatic logic signed [15:0] model_cap(input logic signed [15:0] v);
`ifdef THROW_CLAMP_EN
        if (v > 16'sd255) return 16'sd255;
        if (v < -16'sd255) return -16'sd255;
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic press_to_drag();
        bus.i_mouse_left = 1'b1;
        repeat (3) tick();
        chk("debounce_wait_state", bus.o_state, 3'd0);
        tick();
        chk("drag_entry_state", bus.o_state, 3'd1);
        chk("drag_busy", bus.o_busy, 1'b1);
    endtask

    task automatic release_drag(input int holds, input logic signed [15:0] x,
                                input logic signed [15:0] y, input logic signed [15:0] z);
        vel_t e;
        bit   ok;
        repeat (holds) tick();
        ok = (holds >= 8);
        bus.i_x_vel = x;
        bus.i_y_vel = y;
        bus.i_z_vel = z;
        bus.i_mouse_left = 1'b0;
        if (ok) begin
            e.x = model_cap(x);
            e.y = model_cap(y);
            e.z = model_cap(z);
            sb.push_back(e);
        end
        tick();
        bus.i_x_vel = 16'(~x);
        bus.i_y_vel = 16'(~y);
        bus.i_z_vel = 16'(~z);
        if (ok) begin
            chk("launch_pulse", bus.o_launch, 1'b1);
            chk("launch_state", bus.o_state, 3'd2);
            chk("launch_no_abort", bus.o_abort, 1'b0);
            if (bus.o_launch && sb.size() > 0) begin
                e = sb.pop_front();
                chk("cap_x", bus.o_x_vel, e.x);
                chk("cap_y", bus.o_y_vel, e.y);
                chk("cap_z", bus.o_z_vel, e.z);
                last_x = e.x;
                last_y = e.y;
                last_z = e.z;
            end
            tick();
            exp_cnt = exp_cnt + 8'd1;
            chk("flight_state", bus.o_state, 3'd3);
            chk("launch_one_cycle", bus.o_launch, 1'b0);
            chk("throw_cnt", bus.o_throw_cnt, exp_cnt);
            chk("vel_held_x", bus.o_x_vel, last_x);
        end else begin
            chk("abort_pulse", bus.o_abort, 1'b1);
            chk("abort_no_launch", bus.o_launch, 1'b0);
            chk("abort_state", bus.o_state, 3'd4);
            chk("abort_vel_x", bus.o_x_vel, last_x);
            chk("abort_vel_y", bus.o_y_vel, last_y);
            chk("abort_vel_z", bus.o_z_vel, last_z);
            chk("abort_cnt", bus.o_throw_cnt, exp_cnt);
        end
    endtask

    task automatic end_flight_collision(input int cycles);
        repeat (cycles) tick();
        bus.i_collision_done = 1'b1;
        tick();
        bus.i_collision_done = 1'b0;
        chk("coll_state", bus.o_state, 3'd4);
        chk("coll_speed_clr", bus.o_speed_clr, 1'b1);
        chk("coll_no_timeout", bus.o_timeout, 1'b0);
    endtask

    task automatic back_to_idle();
        bus.i_mouse_left = 1'b0;
        tick();
        chk("idle_state", bus.o_state, 3'd0);
        chk("idle_speed_clr", bus.o_speed_clr, 1'b0);
        chk("idle_busy", bus.o_busy, 1'b0);
        chk("idle_no_abort", bus.o_abort, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic signed [15:0] rx, ry, rz;
        i_rst = 1'b1;
        bus.i_mouse_left = 1'b0;
        bus.i_x_vel = '0;
        bus.i_y_vel = '0;
        bus.i_z_vel = '0;
        bus.i_collision_done = 1'b0;
        tick();
        tick();
        chk("rst_state", bus.o_state, 3'd0);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_launch", bus.o_launch, 1'b0);
        chk("rst_clr", bus.o_speed_clr, 1'b0);
        chk("rst_abort", bus.o_abort, 1'b0);
        chk("rst_timeout", bus.o_timeout, 1'b0);
        chk("rst_cnt", bus.o_throw_cnt, 8'd0);
        chk("rst_vel", {bus.o_x_vel, bus.o_y_vel}, 32'd0);
        i_rst = 1'b0;

        // glitchy press never reaches four consecutive samples
        bus.i_mouse_left = 1'b1;
        repeat (3) tick();
        chk("glitch_state", bus.o_state, 3'd0);
        chk("glitch_busy", bus.o_busy, 1'b0);
        bus.i_mouse_left = 1'b0;
        tick();
        press_to_drag();

        // normal throw
        release_drag(20, 16'sd100, -16'sd50, -16'sd100);
        end_flight_collision(29);
        back_to_idle();
        chk("normal_cnt", bus.o_throw_cnt, 8'd1);

        // short drags, including one below the hold boundary
        press_to_drag();
        release_drag(5, 16'sd1, 16'sd2, 16'sd3);
        back_to_idle();
        press_to_drag();
        release_drag(7, 16'sd4, 16'sd5, 16'sd6);
        back_to_idle();

        // exact hold boundary then timeout
        press_to_drag();
        release_drag(8, 16'sd11, -16'sd12, 16'sd13);
        n = 0;
        while (!bus.o_timeout && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 100);
        chk("timeout_state", bus.o_state, 3'd4);
        chk("timeout_clr", bus.o_speed_clr, 1'b1);
        tick();
        chk("timeout_one_cycle", bus.o_timeout, 1'b0);
        chk("timeout_idle", bus.o_state, 3'd0);

        // collision on the would-be timeout cycle
        press_to_drag();
        release_drag(8, 16'sd21, 16'sd22, -16'sd23);
        repeat (99) tick();
        chk("c99_state", bus.o_state, 3'd3);
        chk("c99_timeout", bus.o_timeout, 1'b0);
        bus.i_collision_done = 1'b1;
        tick();
        bus.i_collision_done = 1'b0;
        chk("c99_clear", bus.o_state, 3'd4);
        chk("c99_no_timeout", bus.o_timeout, 1'b0);
        tick();
        chk("c99_no_timeout_late", bus.o_timeout, 1'b0);
        chk("c99_idle", bus.o_state, 3'd0);

        // clamp behaviour, then held button keeps CLEAR
        press_to_drag();
        release_drag(10, 16'sd1000, -16'sd1000, 16'sd30);
`ifdef THROW_CLAMP_EN
        chk("clamp_x", bus.o_x_vel, 16'sd255);
        chk("clamp_y", bus.o_y_vel, -16'sd255);
`else
        chk("clamp_x", bus.o_x_vel, 16'sd1000);
        chk("clamp_y", bus.o_y_vel, -16'sd1000);
`endif
        chk("clamp_z", bus.o_z_vel, 16'sd30);
        bus.i_mouse_left = 1'b1;
        end_flight_collision(3);
        repeat (10) tick();
        chk("held_state", bus.o_state, 3'd4);
        chk("held_clr", bus.o_speed_clr, 1'b1);
        back_to_idle();

        // collision outside flight is ignored
        bus.i_collision_done = 1'b1;
        tick();
        bus.i_collision_done = 1'b0;
        chk("stray_coll_state", bus.o_state, 3'd0);

        // run throws until the counter wraps
        for (int k = 0; k < 300 && exp_cnt != 8'd0; k++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rz = 16'($urandom);
            press_to_drag();
            release_drag(8 + int'($urandom_range(0, 3)), rx, ry, rz);
            end_flight_collision(int'($urandom_range(0, 5)));
            back_to_idle();
        end
        chk("wrap_cnt", bus.o_throw_cnt, 8'd0);
        chk("wrap_model", exp_cnt, 8'd0);

        // reset during flight
        press_to_drag();
        release_drag(9, 16'sd7, 16'sd8, 16'sd9);
        repeat (5) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        exp_cnt = 8'd0;
        chk("mid_rst_state", bus.o_state, 3'd0);
        chk("mid_rst_launch", bus.o_launch, 1'b0);
        chk("mid_rst_cnt", bus.o_throw_cnt, exp_cnt);
        chk("mid_rst_vel", {bus.o_x_vel, bus.o_z_vel}, 32'd0);
        chk("mid_rst_clr", bus.o_speed_clr, 1'b0);
        chk("mid_rst_busy", bus.o_busy, 1'b0);
        tick();
        chk("post_rst_launch", bus.o_launch, 1'b0);
        chk("post_rst_state", bus.o_state, 3'd0);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/throw_ctrl.md
# throw_ctrl

Sequencer for one mouse-driven throw in the game datapath. Debounces the left button, times the drag, and captures the velocity triple from the `speed` block on release. It then issues a one-cycle launch to the physics stage and waits for collision or timeout. Finally it clears the velocity estimator so the next throw starts from zero history.

## Interface
- `DEBOUNCE`, 4: consecutive high samples of `i_mouse_left` required to arm a drag (≥1)
- `MIN_HOLD`, 8: minimum drag cycles for a valid throw; shorter drags abort
- `TIMEOUT`, 1000000: max cycles in FLIGHT before forced end (< 2^24)
- `MAX_VEL`, 255: saturation magnitude for captured velocities (positive, < 2^15)

- `i_clk` in 1: single clock
- `i_rst` in 1: synchronous reset, active-high
- `i_mouse_left` in 1: raw left button level
- `i_x_vel` / `i_y_vel` / `i_z_vel` in 16 signed: velocity estimates from `speed`
- `i_collision_done` in 1: physics reports end of flight
- `o_launch` out 1: one-cycle launch strobe
- `o_x_vel` / `o_y_vel` / `o_z_vel` out 16 signed: captured (optionally clamped) velocities, held until next capture
- `o_speed_clr` out 1: clear request to `speed` (drives its clear input)
- `o_abort` out 1: one-cycle pulse on a too-short drag
- `o_timeout` out 1: one-cycle pulse on a forced flight end
- `o_busy` out 1: high whenever state ≠ IDLE
- `o_state` out 3: IDLE=0, DRAG=1, LAUNCH=2, FLIGHT=3, CLEAR=4
- `o_throw_cnt` out 8: completed launches, wraps 255→0

## Operation
- Reset: state IDLE; all counters 0; all outputs 0.
- IDLE: `db_cnt` increments while `i_mouse_left`=1 and clears to 0 when it is 0. When `db_cnt` reaches `DEBOUNCE`-1 with the button still high, go to DRAG and clear `hold_cnt`.
- DRAG: `hold_cnt` increments each cycle and saturates at `MIN_HOLD`. On `i_mouse_left`=0:
  - if `hold_cnt` ≥ `MIN_HOLD`: capture `i_*_vel` into the output registers in the same edge, then go to LAUNCH.
  - otherwise: pulse `o_abort`, go to CLEAR, output velocities unchanged.
- LAUNCH: exactly one cycle. `o_launch`=1. `o_throw_cnt` increments. Next state is FLIGHT and `flt_cnt` clears.
- FLIGHT: `flt_cnt` increments.
  - `i_collision_done`=1: go to CLEAR.
  - else, when `flt_cnt` = `TIMEOUT`-1: pulse `o_timeout`, go to CLEAR.
  - Collision and timeout in the same cycle count as a collision; no `o_timeout`.
- CLEAR: `o_speed_clr`=1. Stay while `i_mouse_left`=1, so a held button never re-arms. Go to IDLE on the first cycle the button is 0; `db_cnt` is 0 on entry.
- `i_collision_done` outside FLIGHT is ignored.
- `i_rst` mid-throw: return to IDLE next edge. No `o_launch`. Velocities and count are zeroed.

## Timing
- All outputs are registered; nothing is combinational from inputs.
- Button high from cycle 0: `o_state`=DRAG visible after edge `DEBOUNCE`.
- Release sampled at edge N in DRAG: velocities valid and `o_launch`=1 after edge N; `o_state`=FLIGHT after edge N+1.
- Collision sampled at edge M: `o_speed_clr`=1 after edge M. It stays high for at least 1 cycle, until the button is seen low.
- `o_abort` and `o_timeout` are high for exactly the cycle following the deciding edge.

## Configuration
- `THROW_CLAMP_EN` defined: each captured velocity saturates to [−`MAX_VEL`, +`MAX_VEL`] before registering. Signed compare on the full 16 bits.
- Undefined: captured values pass through unchanged; `MAX_VEL` is unused.

## Test plan
Parameters for all tests: `DEBOUNCE`=4, `MIN_HOLD`=8, `TIMEOUT`=100, `MAX_VEL`=255.

- Glitchy press: button high 3 cycles, low 1, high 3 → stays IDLE, `o_busy`=0. Then high 4 cycles → DRAG.
- Normal throw: drag 20 cycles, release with vel (100, −50, −100), collision 30 cycles later → one `o_launch` pulse, outputs (100, −50, −100), `o_throw_cnt`=1, `o_speed_clr` for 1 cycle, back to IDLE.
- Short drag: release after 5 drag cycles → `o_abort` pulse, no `o_launch`, `o_throw_cnt` unchanged, velocities unchanged.
- Timeout: no collision → `o_timeout` exactly 100 cycles after FLIGHT entry, then CLEAR. Repeat with collision on cycle 99 → no `o_timeout`.
- Clamp: release with (1000, −1000, 30) → (255, −255, 30) with `THROW_CLAMP_EN`; (1000, −1000, 30) without it.
- Held button and wrap: button held through CLEAR → stays CLEAR, no re-arm. After 256 throws, `o_throw_cnt`=0. Assert `i_rst` during FLIGHT → IDLE, all outputs 0.
